// File: rtl/sram_ctrl_avmm_if.sv
// Avalon-MM single-transfer bus bundle between a system master and the SRAM bridge.
// Latency: none, this is wiring only.
// Backpressure: the slave drives waitrequest and the master holds its request while it is high.
interface avalon_mm_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  logic              waitrequest;

  modport master (
    output address, read, write, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/sram_ctrl_avmm.sv
// Avalon-MM slave to asynchronous 16-bit SRAM bridge, one transfer at a time.
// Latency: read data is valid RD_CYC cycles after accept; write busy WR_CYC cycles, read busy RD_CYC+1.
// Backpressure: waitrequest is high in every state except IDLE; the master must hold its request.
module sram_ctrl_avmm #(
  parameter int CLK_PERIOD = 10,
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 16,
  parameter int T_RC       = 45,
  parameter int T_PWE      = 35,
  parameter int T_WC       = 45
) (
  input  logic              clk_i,
  input  logic              rst_i,
  avalon_mm_if.slave        mem_if,
  output logic              wen_o,
  output logic              oen_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              data_en_o,
  output logic [DATA_W-1:0] data_o,
  input  logic [DATA_W-1:0] data_i
);

  // SRAM timing converted from ns to whole clock cycles, rounding up.
  localparam int RD_RAW  = (T_RC + CLK_PERIOD - 1) / CLK_PERIOD;
  localparam int WE_RAW  = (T_PWE + CLK_PERIOD - 1) / CLK_PERIOD;
  localparam int WC_RAW  = (T_WC + CLK_PERIOD - 1) / CLK_PERIOD;
  localparam int RD_CYC  = (RD_RAW < 1) ? 1 : RD_RAW;
  localparam int WE_CYC  = (WE_RAW < 1) ? 1 : WE_RAW;
  // At least one recovery cycle after WE# rises so address/data outlive the pulse.
  localparam int WR_CYC  = (WC_RAW < WE_CYC + 1) ? WE_CYC + 1 : WC_RAW;
  localparam int MAX_CYC = (RD_CYC > WR_CYC) ? RD_CYC : WR_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // Counter value seen on the last cycle of each timed state; the counter
  // restarts at zero on entry, so a state lasting N cycles ends when it reads N-1.
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYC - 1);
  localparam logic [CNT_W-1:0] WE_LAST = CNT_W'(WE_CYC - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYC - WE_CYC - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    WREC  = 3'd3,
    TURN  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wen_q, wen_d;
  logic              oen_q, oen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              den_q, den_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvld_q, rvld_d;
  logic              wait_q, wait_d;
  logic              accept;

  // A request is taken only while IDLE is advertised on the bus; this also
  // covers the first cycle after reset where waitrequest is still high.
  assign accept = (state_q == IDLE) && !wait_q;

  // Next-state and registered-output logic for the SRAM cycle sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    wen_d   = wen_q;
    oen_d   = oen_q;
    addr_d  = addr_q;
    den_d   = den_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    rvld_d  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          if (mem_if.write) begin
            // Write wins over a simultaneous read; the read is dropped.
            addr_d  = mem_if.address;
            dout_d  = mem_if.writedata;
            den_d   = 1'b1;
            wen_d   = 1'b0;
            state_d = WRITE;
          end else if (mem_if.read) begin
            addr_d  = mem_if.address;
            oen_d   = 1'b0;
            state_d = READ;
          end
        end
      end

      READ: begin
        if (cnt_q == RD_LAST) begin
          rdata_d = data_i;
          rvld_d  = 1'b1;
          oen_d   = 1'b1;
          state_d = TURN;
        end
      end

      // One dead cycle after OE# rises so the SRAM releases DQ before any write drives it.
      TURN: begin
        state_d = IDLE;
      end

      WRITE: begin
        if (cnt_q == WE_LAST) begin
          wen_d   = 1'b1;
          state_d = WREC;
        end
      end

      // Address and data stay put after WE# rises to cover hold and tWC.
      WREC: begin
        if (cnt_q == WR_LAST) begin
          den_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        wen_d   = 1'b1;
        oen_d   = 1'b1;
        den_d   = 1'b0;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end

    wait_d = (state_d != IDLE);
  end

  // State, counter and every output are registered; reset aborts any SRAM cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wen_q   <= 1'b1;
      oen_q   <= 1'b1;
      addr_q  <= '0;
      den_q   <= 1'b0;
      dout_q  <= '0;
      rdata_q <= '0;
      rvld_q  <= 1'b0;
      wait_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      oen_q   <= oen_d;
      addr_q  <= addr_d;
      den_q   <= den_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      rvld_q  <= rvld_d;
      wait_q  <= wait_d;
    end
  end

  assign wen_o     = wen_q;
  assign oen_o     = oen_q;
  assign addr_o    = addr_q;
  assign data_en_o = den_q;
  assign data_o    = dout_q;

  assign mem_if.readdata      = rdata_q;
  assign mem_if.readdatavalid = rvld_q;
  assign mem_if.waitrequest   = wait_q;

endmodule

// File: tb/tb_sram_ctrl_avmm.sv
// Bench for the Avalon-MM to SRAM bridge with a behavioural SRAM that enforces tRC/tPWE.
// Latency: checks read latency, WE# pulse length and busy windows for 10 ns and 20 ns clocks.
// Backpressure: master tasks hold requests until waitrequest drops, with bounded waits.
module tb_sram_ctrl_avmm;
  localparam int AW = 18;
  localparam int DW = 16;

  logic clk  = 1'b0;
  logic clk2 = 1'b0;
  logic rst  = 1'b1;
  always #5  clk  = ~clk;
  always #10 clk2 = ~clk2;

  int checks = 0;
  int errors = 0;

  // ---------------- main DUT, 10 ns clock ----------------
  avalon_mm_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  logic          wen, oen, den;
  logic [AW-1:0] addr;
  logic [DW-1:0] dout, din;

  sram_ctrl_avmm dut (
    .clk_i(clk), .rst_i(rst), .mem_if(bus),
    .wen_o(wen), .oen_o(oen), .addr_o(addr),
    .data_en_o(den), .data_o(dout), .data_i(din)
  );

  // ---------------- second DUT, 20 ns clock ----------------
  avalon_mm_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();
  logic          wen2, oen2, den2;
  logic [AW-1:0] addr2;
  logic [DW-1:0] dout2, din2;

  sram_ctrl_avmm #(.CLK_PERIOD(20)) dut2 (
    .clk_i(clk2), .rst_i(rst), .mem_if(bus2),
    .wen_o(wen2), .oen_o(oen2), .addr_o(addr2),
    .data_en_o(den2), .data_o(dout2), .data_i(din2)
  );

  // ---------------- SRAM model for main DUT ----------------
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          rd_ok = 1'b0;
  time           we_t = 0, oe_t = 0;
  int            we_low_cyc = 0, tviol = 0, iviol = 0;

  // Data appears only once tRC has elapsed with OE# low.
  assign din = (!oen && rd_ok) ? mem[addr] : 16'hDEAD;
  always begin
    @(negedge oen);
    oe_t = $time;
    #45;
    if (!oen) rd_ok = 1'b1;
  end
  always @(posedge oen) begin
    rd_ok = 1'b0;
    if (rst === 1'b0 && ($time - oe_t) < 45) tviol++;
  end
  always @(negedge wen) we_t = $time;
  always @(posedge wen) begin
    if (rst === 1'b0) begin
      if (($time - we_t) < 35) tviol++;
      we_low_cyc = int'(($time - we_t) / 10);
      if (den === 1'b1) mem[addr] = dout;
    end
  end
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (!oen && !wen) iviol++;
      if (den && !oen)  iviol++;
    end
  end

  // ---------------- SRAM model for second DUT (16 words) ----------------
  logic [DW-1:0] mem2 [0:15];
  logic          rd_ok2 = 1'b0;
  time           we_t2 = 0, oe_t2 = 0;
  int            we_low_cyc2 = 0, tviol2 = 0;

  assign din2 = (!oen2 && rd_ok2) ? mem2[addr2[3:0]] : 16'hDEAD;
  always begin
    @(negedge oen2);
    oe_t2 = $time;
    #45;
    if (!oen2) rd_ok2 = 1'b1;
  end
  always @(posedge oen2) begin
    rd_ok2 = 1'b0;
    if (rst === 1'b0 && ($time - oe_t2) < 45) tviol2++;
  end
  always @(negedge wen2) we_t2 = $time;
  always @(posedge wen2) begin
    if (rst === 1'b0) begin
      if (($time - we_t2) < 35) tviol2++;
      we_low_cyc2 = int'(($time - we_t2) / 20);
      if (den2 === 1'b1) mem2[addr2[3:0]] = dout2;
    end
  end

  // Scoreboard of everything written through the main DUT.
  logic [DW-1:0] sb [int];

  function automatic logic [DW-1:0] init_pat(input logic [AW-1:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting on DUT", nm);
  endtask

  // Holds the driven request until waitrequest is low, returns #1 after the accept edge.
  task automatic wait_accept(output int n);
    n = 0;
    @(negedge clk);
    while (bus.waitrequest !== 1'b0 && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (n >= 40) timeout("accept");
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit meas,
                          output int n, output int busy);
    bus.write     = 1'b1;
    bus.address   = a;
    bus.writedata = d;
    wait_accept(n);
    bus.write = 1'b0;
    sb[int'(a)] = d;
    busy = 0;
    if (meas) begin
      @(negedge clk);
      while (bus.waitrequest === 1'b1 && busy < 40) begin
        busy++;
        @(negedge clk);
      end
    end
  endtask

  // tail = {waitrequest at rdv edge, readdatavalid one edge later, waitrequest one edge later}
  task automatic do_read(input logic [AW-1:0] a, output int n, output int lat,
                         output logic [DW-1:0] d, output logic [2:0] tail);
    bus.read    = 1'b1;
    bus.address = a;
    wait_accept(n);
    bus.read = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (bus.readdatavalid !== 1'b1 && lat < 40);
    if (lat >= 40) timeout("readdatavalid");
    d       = bus.readdata;
    tail[2] = bus.waitrequest;
    @(posedge clk);
    #1;
    tail[1] = bus.readdatavalid;
    tail[0] = bus.waitrequest;
  endtask

  typedef struct {
    bit            wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;   // write data, or expected read data
  } vec_t;

  vec_t vecs [10];

  initial begin
    int n, busy, lat, k;
    logic [DW-1:0] rd;
    logic [2:0]    tail;
    logic [AW-1:0] ra;
    logic [DW-1:0] rexp;
    logic [31:0]   r;

    vecs[0] = '{1'b1, 18'h3FFFF, 16'hFFFF};
    vecs[1] = '{1'b1, 18'h00000, 16'h0001};
    vecs[2] = '{1'b0, 18'h3FFFF, 16'hFFFF};
    vecs[3] = '{1'b0, 18'h00000, 16'h0001};
    vecs[4] = '{1'b1, 18'h15555, 16'h5555};
    vecs[5] = '{1'b0, 18'h15555, 16'h5555};
    vecs[6] = '{1'b1, 18'h2AAAA, 16'hAAAA};
    vecs[7] = '{1'b1, 18'h2AAAA, 16'h0F0F};
    vecs[8] = '{1'b0, 18'h2AAAA, 16'h0F0F};
    vecs[9] = '{1'b0, 18'h00123, 16'h5B79};

    for (int i = 0; i < (1 << AW); i++) mem[i] = init_pat(AW'(i));
    for (int i = 0; i < 16; i++) mem2[i] = 16'h0000;

    bus.read = 1'b0;  bus.write = 1'b0;  bus.address = '0;  bus.writedata = '0;
    bus2.read = 1'b0; bus2.write = 1'b0; bus2.address = '0; bus2.writedata = '0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wen",   32'(wen), 32'd1);
    chk("rst_oen",   32'(oen), 32'd1);
    chk("rst_den",   32'(den), 32'd0);
    chk("rst_addr",  32'(addr), 32'd0);
    chk("rst_dout",  32'(dout), 32'd0);
    chk("rst_rdata", 32'(bus.readdata), 32'd0);
    chk("rst_rdv",   32'(bus.readdatavalid), 32'd0);
    chk("rst_wait",  32'(bus.waitrequest), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Write 0xA5A5 then read it back.
    do_write(18'h00010, 16'hA5A5, 1'b1, n, busy);
    chk("wr_we_low_cycles", 32'(we_low_cyc), 32'd4);
    chk("wr_busy_cycles", 32'(busy), 32'd5);
    do_read(18'h00010, n, lat, rd, tail);
    chk("rd_latency", 32'(lat), 32'd5);
    chk("rd_data", 32'(rd), 32'hA5A5);
    chk("rd_tail", 32'(tail), 32'b100);

    // Table of directed transfers including address-space boundaries.
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].a, vecs[i].d, 1'b1, n, busy);
        chk($sformatf("vec%0d_wr_busy", i), 32'(busy), 32'd5);
        chk($sformatf("vec%0d_we_low", i), 32'(we_low_cyc), 32'd4);
      end else begin
        do_read(vecs[i].a, n, lat, rd, tail);
        chk($sformatf("vec%0d_rd_lat", i), 32'(lat), 32'd5);
        chk($sformatf("vec%0d_rd_data", i), 32'(rd), 32'(vecs[i].d));
        chk($sformatf("vec%0d_rd_tail", i), 32'(tail), 32'b100);
      end
    end

    // Read and write high together: write wins, read dropped.
    bus.read = 1'b1;
    do_write(18'h00040, 16'h1357, 1'b1, n, busy);
    bus.read = 1'b0;
    chk("both_no_rdv", 32'(bus.readdatavalid), 32'd0);
    do_read(18'h00040, n, lat, rd, tail);
    chk("both_wr_data", 32'(rd), 32'h1357);

    // Read held through a write's busy window.
    do_write(18'h00050, 16'h2468, 1'b0, n, busy);
    do_read(18'h00050, n, lat, rd, tail);
    chk("held_rd_wait_cycles", 32'(n), 32'd5);
    chk("held_rd_data", 32'(rd), 32'h2468);
    chk("held_rd_lat", 32'(lat), 32'd5);

    // Asynchronous reset in the middle of a write.
    do_write(18'h00020, 16'h1234, 1'b0, n, busy);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_ctl", 32'({wen, oen, den, bus.waitrequest, bus.readdatavalid}), 32'b11010);
    chk("midrst_addr", 32'(addr), 32'd0);
    chk("midrst_dout", 32'(dout), 32'd0);
    sb.delete(32'h20);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    do_read(18'h00010, n, lat, rd, tail);
    chk("postrst_rd_lat", 32'(lat), 32'd5);
    chk("postrst_rd_data", 32'(rd), 32'hA5A5);

    // Random traffic against the scoreboard; address 0x20 has unknown content after the abort.
    for (int i = 0; i < 3000; i++) begin
      r  = $urandom;
      ra = r[0] ? AW'($urandom_range(0, (1 << AW) - 1)) : AW'($urandom_range(0, 31));
      if (ra == 18'h00020) ra = 18'h00021;
      if (r[1]) begin
        do_write(ra, DW'($urandom), 1'b0, n, busy);
      end else begin
        rexp = sb.exists(int'(ra)) ? sb[int'(ra)] : init_pat(ra);
        do_read(ra, n, lat, rd, tail);
        chk($sformatf("rand%0d_rd_%05h", i, ra), 32'(rd), 32'(rexp));
      end
    end

    chk("interlock_violations", 32'(iviol), 32'd0);
    chk("timing_violations", 32'(tviol), 32'd0);

    // 20 ns clock instance: RD_CYC=3, WE_CYC=2, WR_CYC=3.
    @(negedge clk2);
    bus2.write = 1'b1; bus2.address = 18'h00003; bus2.writedata = 16'hBEEF;
    k = 0;
    while (bus2.waitrequest !== 1'b0 && k < 20) begin k++; @(negedge clk2); end
    if (k >= 20) timeout("clk20_wr_accept");
    @(posedge clk2);
    #1;
    bus2.write = 1'b0;
    busy = 0;
    @(negedge clk2);
    while (bus2.waitrequest === 1'b1 && busy < 20) begin busy++; @(negedge clk2); end
    chk("clk20_we_low", 32'(we_low_cyc2), 32'd2);
    chk("clk20_wr_busy", 32'(busy), 32'd3);
    bus2.read = 1'b1; bus2.address = 18'h00003;
    k = 0;
    while (bus2.waitrequest !== 1'b0 && k < 20) begin k++; @(negedge clk2); end
    if (k >= 20) timeout("clk20_rd_accept");
    @(posedge clk2);
    #1;
    bus2.read = 1'b0;
    lat = 0;
    do begin
      @(posedge clk2);
      #1;
      lat++;
    end while (bus2.readdatavalid !== 1'b1 && lat < 20);
    chk("clk20_rd_lat", 32'(lat), 32'd3);
    chk("clk20_rd_data", 32'(bus2.readdata), 32'hBEEF);
    repeat (2) @(posedge clk2);
    chk("clk20_timing_violations", 32'(tviol2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
